// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the mux select arbiter.
// The arbiter FSM has two states: no owner, or one owner held in grant/sel.
package mux_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int SEL_W     = $clog2(N_REQ_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Index of the highest set bit; only meaningful for one-hot inputs.
    function automatic int onehot_to_bin(input logic [31:0] oh);
        int b;
        b = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) b = i;
        end
        return b;
    endfunction

endpackage

// File: rtl/mux_arb_pick.sv
// Combinational winner selection: fixed priority (lowest index) or round-robin
// starting at rr_ptr. Bits set in mask are excluded from the pick.
module mux_arb_pick #(
    parameter int N_REQ = 4,
    parameter int SW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [SW-1:0]    rr_ptr,
    input  logic             mode,
    output logic             found,
    output logic [SW-1:0]    winner
);

    logic [N_REQ-1:0] eff;
    logic [N_REQ-1:0] hi_mask;
    logic [N_REQ-1:0] cand;

    always_comb begin
        eff = req & ~mask;
        for (int i = 0; i < N_REQ; i++) begin
            hi_mask[i] = (i >= int'(rr_ptr));
        end
        // Round-robin: try indices at/above rr_ptr first, else wrap to the bottom.
        if (mode && |(eff & hi_mask)) cand = eff & hi_mask;
        else                          cand = eff;
    end

    always_comb begin
        found  = |cand;
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand[i]) winner = SW'(i);
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Arbitrates N_REQ requesters onto one shared N:1 data mux. Holds the grant
// until release, or preempts the owner after MAX_HOLD cycles if others wait.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int DW       = 8,
    parameter  int MAX_HOLD = 8,
    localparam int SW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int HW       = $clog2(MAX_HOLD + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic                mode,
    input  logic [N_REQ*DW-1:0] data_in,
    output logic [N_REQ-1:0]    grant,
    output logic [SW-1:0]       sel,
    output logic                out_valid,
    output logic [DW-1:0]       data_out,
    output logic                preempt
);

    arb_state_t       state, nxt_state;
    logic [N_REQ-1:0] nxt_grant;
    logic [SW-1:0]    nxt_sel;
    logic [SW-1:0]    rr_ptr, nxt_rr;
    logic [HW-1:0]    hold_cnt, nxt_hold;
    logic [N_REQ-1:0] pick_mask;
    logic             found;
    logic [SW-1:0]    winner;
    logic             others;
    logic             release_own;
    logic             timeout;
    logic             rearb;

    mux_arb_pick #(.N_REQ(N_REQ), .SW(SW)) u_pick (
        .req    (req),
        .mask   (pick_mask),
        .rr_ptr (rr_ptr),
        .mode   (mode),
        .found  (found),
        .winner (winner)
    );

    always_comb begin
        others      = |(req & ~grant);
        release_own = (state == OWN) && !req[sel];
        // A release in the timeout cycle wins: no preempt is reported.
        timeout     = (state == OWN) && req[sel] && (hold_cnt == HW'(MAX_HOLD)) && others;
        preempt     = timeout && !rst;
        pick_mask   = (state == OWN) ? grant : '0;

        nxt_state = state;
        nxt_grant = grant;
        nxt_sel   = sel;
        nxt_hold  = hold_cnt;
        nxt_rr    = rr_ptr;
        rearb     = 1'b0;

        unique case (state)
            IDLE: rearb = 1'b1;
            OWN:  rearb = release_own || timeout;
            default: rearb = 1'b1;
        endcase

        if (rearb) begin
            if (found) begin
                nxt_state = OWN;
                nxt_grant = N_REQ'(1) << winner;
                nxt_sel   = winner;
                nxt_hold  = HW'(1);
                nxt_rr    = (winner == SW'(N_REQ - 1)) ? '0 : winner + SW'(1);
            end else begin
                nxt_state = IDLE;
                nxt_grant = '0;
                nxt_sel   = '0;
                nxt_hold  = '0;
            end
        end else if (hold_cnt != HW'(MAX_HOLD)) begin
            nxt_hold = hold_cnt + HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= nxt_state;
            grant    <= nxt_grant;
            sel      <= nxt_sel;
            rr_ptr   <= nxt_rr;
            hold_cnt <= nxt_hold;
        end
    end

    logic [DW-1:0] slices [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign slices[i] = data_in[i*DW +: DW];
    end

    assign out_valid = |grant;
    assign data_out  = out_valid ? slices[sel] : '0;

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_sel:    assert property (@(posedge clk) disable iff (rst)
                  (grant != '0) |-> (onehot_to_bin(32'(grant)) == int'(sel)));

endmodule
